// File: rtl/param_mode_reg.sv
// Opcode-driven WIDTH-bit register: load, load-doubled, inc/dec, and a multi-cycle
// RUN counter, with wrap or saturate overflow policy and a sticky overflow flag.
module param_mode_reg #(
  parameter int WIDTH    = 8,
  parameter int STEP     = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam logic [2:0] OP_HOLD   = 3'b000;
  localparam logic [2:0] OP_LOAD   = 3'b001;
  localparam logic [2:0] OP_LOADX2 = 3'b010;
  localparam logic [2:0] OP_INC    = 3'b011;
  localparam logic [2:0] OP_DEC    = 3'b100;
  localparam logic [2:0] OP_RUN    = 3'b101;
  localparam logic [2:0] OP_ABORT  = 3'b110;
  localparam logic [2:0] OP_CLRF   = 3'b111;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] STEP_V   = WIDTH'(STEP);
  localparam bit               SAT      = (SATURATE != 0);

  // State is kept as a named register so checkers can bind to state_q directly.
  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  // One extra bit on each result carries the overflow/borrow out.
  logic [WIDTH:0] sum_step, sum_inc, diff_dec, dbl;
  logic           ovf_ev, clr_flag;

  assign sum_step = {1'b0, data_q} + {1'b0, STEP_V};
  assign sum_inc  = {1'b0, data_q} + {1'b0, ONE};
  assign diff_dec = {1'b0, data_q} - {1'b0, ONE};
  assign dbl      = {data_in, 1'b0};

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    ovf_ev   = 1'b0;
    clr_flag = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          case (op)
            OP_LOAD: data_d = data_in;
            OP_LOADX2: begin
              ovf_ev = dbl[WIDTH];
              data_d = (dbl[WIDTH] && SAT) ? ALL_ONES : dbl[WIDTH-1:0];
            end
            OP_INC: begin
              ovf_ev = sum_inc[WIDTH];
              data_d = (sum_inc[WIDTH] && SAT) ? ALL_ONES : sum_inc[WIDTH-1:0];
            end
            OP_DEC: begin
              ovf_ev = diff_dec[WIDTH];
              data_d = (diff_dec[WIDTH] && SAT) ? '0 : diff_dec[WIDTH-1:0];
            end
            OP_RUN: begin
              if (data_in == '0) begin
                done_d = 1'b1;
              end else begin
                state_d = S_RUN;
                cnt_d   = data_in;
              end
            end
            OP_CLRF: clr_flag = 1'b1;
            OP_HOLD, OP_ABORT: ;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (en && op == OP_ABORT) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          ovf_ev = sum_step[WIDTH];
          data_d = (sum_step[WIDTH] && SAT) ? ALL_ONES : sum_step[WIDTH-1:0];
          cnt_d  = cnt_q - ONE;
          if (cnt_q == ONE) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    ovf_d  = (ovf_q & ~clr_flag) | ovf_ev;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_out = data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_param_mode_reg.sv
// Directed-vector bench for param_mode_reg: three instances cover 4-bit wrap,
// 4-bit saturate and 8-bit STEP=3 RUN behaviour; a monitor pops expected results.
module tb_param_mode_reg;

  localparam logic [2:0] OP_HOLD   = 3'b000;
  localparam logic [2:0] OP_LOAD   = 3'b001;
  localparam logic [2:0] OP_LOADX2 = 3'b010;
  localparam logic [2:0] OP_INC    = 3'b011;
  localparam logic [2:0] OP_DEC    = 3'b100;
  localparam logic [2:0] OP_RUN    = 3'b101;
  localparam logic [2:0] OP_ABORT  = 3'b110;
  localparam logic [2:0] OP_CLRF   = 3'b111;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       en;
  logic [2:0] op;
  logic [7:0] din;

  logic [3:0] d0, d1;
  logic [7:0] d2;
  logic       b0, b1, b2, dn0, dn1, dn2, o0, o1, o2;

  param_mode_reg #(.WIDTH(4), .STEP(1), .SATURATE(0)) u_wrap4 (
    .clk(clk), .rst(rst), .en(en), .op(op), .data_in(din[3:0]),
    .data_out(d0), .busy(b0), .done(dn0), .ovf(o0));

  param_mode_reg #(.WIDTH(4), .STEP(1), .SATURATE(1)) u_sat4 (
    .clk(clk), .rst(rst), .en(en), .op(op), .data_in(din[3:0]),
    .data_out(d1), .busy(b1), .done(dn1), .ovf(o1));

  param_mode_reg #(.WIDTH(8), .STEP(3), .SATURATE(0)) u_run8 (
    .clk(clk), .rst(rst), .en(en), .op(op), .data_in(din),
    .data_out(d2), .busy(b2), .done(dn2), .ovf(o2));

  // scoreboard: {data[7:0], busy, done, ovf}
  logic [10:0] exp_q[$];
  string       name_q[$];
  int          sel;
  int          vectors;
  int          miscompares;
  event        sample_ev;

  function automatic logic [10:0] observed();
    case (sel)
      0:       return {4'h0, d0, b0, dn0, o0};
      1:       return {4'h0, d1, b1, dn1, o1};
      default: return {d2, b2, dn2, o2};
    endcase
  endfunction

  task automatic check_one();
    logic [10:0] e, a;
    string       nm;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = observed();
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s: got data=%h busy=%b done=%b ovf=%b, expected data=%h busy=%b done=%b ovf=%b",
                 nm, a[10:3], a[2], a[1], a[0], e[10:3], e[2], e[1], e[0]);
      end
    end
  endtask

  // monitor: samples on the falling edge, or immediately on demand for async reset
  always @(negedge clk) check_one();
  always @(sample_ev) check_one();

  // driver tasks
  task automatic step(input logic e, input logic [2:0] o, input logic [7:0] d,
                      input logic [7:0] xd, input logic xb, input logic xdn,
                      input logic xo, input string nm);
    @(negedge clk);
    en  = e;
    op  = o;
    din = d;
    @(posedge clk);
    #1;
    exp_q.push_back({xd, xb, xdn, xo});
    name_q.push_back(nm);
  endtask

  // Raise reset between clock edges and check outputs before the next rising edge.
  task automatic async_reset(input string nm);
    @(negedge clk);
    #1;
    rst = 1'b1;
    en  = 1'b0;
    #1;
    exp_q.push_back(11'h000);
    name_q.push_back(nm);
    -> sample_ev;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int waited;
    vectors     = 0;
    miscompares = 0;
    sel         = 0;
    rst         = 1'b1;
    en          = 1'b0;
    op          = OP_HOLD;
    din         = 8'h00;
    #2;
    exp_q.push_back(11'h000);
    name_q.push_back("reset_state");
    -> sample_ev;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 4-bit wrap
    sel = 0;
    step(1, OP_LOAD,   8'h05, 8'h05, 0, 0, 0, "w4_load5");
    async_reset("w4_async_rst");
    step(0, OP_HOLD,   8'h00, 8'h00, 0, 0, 0, "w4_after_rst");
    step(1, OP_LOAD,   8'h09, 8'h09, 0, 0, 0, "w4_load9");
    step(1, OP_LOADX2, 8'h09, 8'h02, 0, 0, 1, "w4_loadx2_wrap");
    step(1, OP_CLRF,   8'h00, 8'h02, 0, 0, 0, "w4_clrf");
    step(1, OP_LOAD,   8'h0F, 8'h0F, 0, 0, 0, "w4_loadF");
    step(1, OP_INC,    8'h00, 8'h00, 0, 0, 1, "w4_inc_wrap");
    step(1, OP_CLRF,   8'h00, 8'h00, 0, 0, 0, "w4_clrf2");
    step(1, OP_DEC,    8'h00, 8'h0F, 0, 0, 1, "w4_dec_wrap");
    step(1, OP_HOLD,   8'h03, 8'h0F, 0, 0, 1, "w4_hold");
    step(1, OP_ABORT,  8'h03, 8'h0F, 0, 0, 1, "w4_abort_idle");
    step(0, OP_LOAD,   8'h03, 8'h0F, 0, 0, 1, "w4_en_low");

    // 4-bit saturate
    async_reset("s4_async_rst");
    sel = 1;
    step(1, OP_LOAD,   8'h0E, 8'h0E, 0, 0, 0, "s4_loadE");
    step(1, OP_INC,    8'h00, 8'h0F, 0, 0, 0, "s4_inc_to_max");
    step(1, OP_INC,    8'h00, 8'h0F, 0, 0, 1, "s4_inc_clamp");
    step(1, OP_LOAD,   8'h00, 8'h00, 0, 0, 1, "s4_load0");
    step(1, OP_DEC,    8'h00, 8'h00, 0, 0, 1, "s4_dec_clamp");
    step(1, OP_CLRF,   8'h00, 8'h00, 0, 0, 0, "s4_clrf");
    step(1, OP_DEC,    8'h00, 8'h00, 0, 0, 1, "s4_dec_clamp_sets");
    step(1, OP_LOADX2, 8'h09, 8'h0F, 0, 0, 1, "s4_loadx2_clamp");

    // 8-bit, STEP=3 RUN behaviour
    async_reset("r8_async_rst");
    sel = 2;
    step(1, OP_LOAD,   8'h10, 8'h10, 0, 0, 0, "r8_load10");
    step(1, OP_RUN,    8'h04, 8'h10, 1, 0, 0, "r8_run4_start");
    step(1, OP_INC,    8'h00, 8'h13, 1, 0, 0, "r8_step1_inc_ignored");
    step(0, OP_HOLD,   8'h00, 8'h16, 1, 0, 0, "r8_step2");
    step(1, OP_CLRF,   8'h00, 8'h19, 1, 0, 0, "r8_step3_clrf_ignored");
    step(0, OP_HOLD,   8'h00, 8'h1C, 0, 1, 0, "r8_step4_done");
    step(0, OP_HOLD,   8'h00, 8'h1C, 0, 0, 0, "r8_done_one_cycle");
    step(1, OP_RUN,    8'h00, 8'h1C, 0, 1, 0, "r8_run0_done");
    step(0, OP_HOLD,   8'h00, 8'h1C, 0, 0, 0, "r8_run0_after");
    step(1, OP_RUN,    8'h0A, 8'h1C, 1, 0, 0, "r8_run10_start");
    step(0, OP_HOLD,   8'h00, 8'h1F, 1, 0, 0, "r8_run10_step1");
    step(0, OP_HOLD,   8'h00, 8'h22, 1, 0, 0, "r8_run10_step2");
    step(1, OP_ABORT,  8'h00, 8'h22, 0, 1, 0, "r8_abort");
    step(0, OP_HOLD,   8'h00, 8'h22, 0, 0, 0, "r8_abort_after");
    step(1, OP_LOAD,   8'hFE, 8'hFE, 0, 0, 0, "r8_loadFE");
    step(1, OP_RUN,    8'h02, 8'hFE, 1, 0, 0, "r8_run2_start");
    step(0, OP_HOLD,   8'h00, 8'h01, 1, 0, 1, "r8_run_wrap");
    step(0, OP_HOLD,   8'h00, 8'h04, 0, 1, 1, "r8_run2_done");
    step(1, OP_CLRF,   8'h00, 8'h04, 0, 0, 0, "r8_clrf");
    step(1, OP_RUN,    8'h05, 8'h04, 1, 0, 0, "r8_run5_start");
    step(0, OP_HOLD,   8'h00, 8'h07, 1, 0, 0, "r8_run5_step1");
    step(0, OP_HOLD,   8'h00, 8'h0A, 1, 0, 0, "r8_run5_step2");
    async_reset("r8_rst_mid_run");
    step(0, OP_HOLD,   8'h00, 8'h00, 0, 0, 0, "r8_no_done_after_rst");
    step(1, OP_LOAD,   8'h5A, 8'h5A, 0, 0, 0, "r8_load_after_rst");

    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
